// File: rtl/sram_ctrl_master.sv
// Initiator-side controller for a synchronous 16x8 SRAM: single or burst
// reads/fills taken on a valid/ready request port, read bytes returned on a backpressured port.
module sram_ctrl_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              wr_done,
  output logic              busy,
  output logic              mem_cs,
  output logic              mem_rw_bar,
  output logic [ADDR_W-1:0] mem_abus,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAP, RSP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  // mem_abus doubles as the burst address register and mem_wdata as the latched fill byte,
  // so both naturally hold their last values between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      wr_done    <= 1'b0;
      busy       <= 1'b0;
      mem_cs     <= 1'b0;
      mem_rw_bar <= 1'b1;
      mem_abus   <= '0;
      mem_wdata  <= '0;
    end else begin
      wr_done <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= req_len;
            mem_cs    <= 1'b1;
            mem_abus  <= req_addr;
            if (req_we) begin
              state      <= WR;
              mem_rw_bar <= 1'b0;
              mem_wdata  <= req_wdata;
            end else begin
              state      <= RD_ISSUE;
              mem_rw_bar <= 1'b1;
            end
          end
        end
        WR: begin
          if (cnt == '0) begin
            state      <= IDLE;
            mem_cs     <= 1'b0;
            mem_rw_bar <= 1'b1;
            wr_done    <= 1'b1;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end else begin
            cnt      <= cnt - 1'b1;
            mem_abus <= mem_abus + 1'b1;
          end
        end
        RD_ISSUE: begin
          state  <= RD_CAP;
          mem_cs <= 1'b0;
        end
        // The SRAM registered its read data at the end of RD_ISSUE; it is valid now.
        RD_CAP: begin
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_data  <= mem_rdata;
          rsp_addr  <= mem_abus;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (cnt == '0) begin
              state     <= IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              state    <= RD_ISSUE;
              cnt      <= cnt - 1'b1;
              mem_abus <= mem_abus + 1'b1;
              mem_cs   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl_master.sv
// Bench for sram_ctrl_master: SRAM model, table-driven and random requests,
// and hand-written reset / back-to-back sequences checked against a reference memory.
module tb_sram_ctrl_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_addr;
  logic       wr_done;
  logic       busy;
  logic       mem_cs;
  logic       mem_rw_bar;
  logic [3:0] mem_abus;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] sram [16];
  logic [7:0] ref_mem [16];

  int compared = 0;
  int failed = 0;
  int cs_count = 0;
  int accept_count = 0;
  int hs_count = 0;
  logic [7:0] last_rsp_data = '0;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [3:0] len;
    logic [7:0] wdata;
    int         stall_pct;
    int         exp_cs;
    int         exp_done;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  sram_ctrl_master #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .wr_done(wr_done), .busy(busy),
    .mem_cs(mem_cs), .mem_rw_bar(mem_rw_bar), .mem_abus(mem_abus),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous SRAM with registered read data.
  always @(posedge clk) begin
    if (mem_cs && !mem_rw_bar) sram[mem_abus] <= mem_wdata;
    if (mem_cs && mem_rw_bar) mem_rdata <= sram[mem_abus];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) accept_count++;
    if (!rst && rsp_valid && rsp_ready) begin
      hs_count++;
      last_rsp_data = rsp_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_cs) cs_count++;
      if (rsp_valid) checkOutput("noCsWhileRsp", {31'b0, mem_cs}, 32'd0);
      if (req_ready) checkOutput("readyImpliesIdle", {31'b0, busy}, 32'd0);
    end
  end

  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [3:0] len,
                               input logic [7:0] wdata);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wdata;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("acceptTimeout", 32'd0, 32'd1);
    cs_count = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic runRequest(input logic we, input logic [3:0] addr, input logic [3:0] len,
                            input logic [7:0] wdata, input int stall_pct,
                            input int exp_cs, input int exp_done);
    int n = int'(len) + 1;
    int cycles = 0;
    int got = 0;
    int first_seen = 0;
    int done_at = 0;
    logic [3:0] a = addr;
    applyStimulus(we, addr, len, wdata);
    if (we) begin
      do begin
        @(negedge clk);
        cycles++;
      end while (!wr_done && cycles < 100);
      checkOutput("wrDoneCycle", cycles, exp_done);
      for (int k = 0; k < n; k++) begin
        ref_mem[a] = wdata;
        a++;
      end
      @(negedge clk);
      checkOutput("wrDonePulse", {31'b0, wr_done}, 32'd0);
      checkOutput("wrCsCycles", cs_count, exp_cs);
    end else begin
      while (got < n && cycles < 2000) begin
        @(negedge clk);
        cycles++;
        if (rsp_valid) begin
          if (first_seen == 0) first_seen = cycles;
          checkOutput("rspData", rsp_data, ref_mem[a]);
          checkOutput("rspAddr", rsp_addr, a);
          rsp_ready = ($urandom_range(0, 99) >= stall_pct);
          if (rsp_ready) begin
            got++;
            a++;
            done_at = cycles;
          end
        end else begin
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("readBeats", got, n);
      checkOutput("firstByteLatency", first_seen, 32'd3);
      if (exp_done >= 0) checkOutput("readDoneCycle", done_at, exp_done);
      checkOutput("rdCsCycles", cs_count, exp_cs);
      checkOutput("readyAfterRead", {31'b0, req_ready}, 32'd1);
      checkOutput("busyAfterRead", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic checkSram();
    for (int i = 0; i < 16; i++) checkOutput("sramWord", sram[i], ref_mem[i]);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0;
    int hs0;
    int guard;
    logic [7:0] exp_rd;

    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    vecs[0] = '{we: 1'b1, addr: 4'd0,  len: 4'd15, wdata: 8'h00, stall_pct: 0,  exp_cs: 16, exp_done: 17};
    vecs[1] = '{we: 1'b1, addr: 4'd3,  len: 4'd0,  wdata: 8'hA5, stall_pct: 0,  exp_cs: 1,  exp_done: 2};
    vecs[2] = '{we: 1'b0, addr: 4'd3,  len: 4'd0,  wdata: 8'h00, stall_pct: 0,  exp_cs: 1,  exp_done: 3};
    vecs[3] = '{we: 1'b1, addr: 4'd14, len: 4'd3,  wdata: 8'h3C, stall_pct: 0,  exp_cs: 4,  exp_done: 5};
    vecs[4] = '{we: 1'b0, addr: 4'd14, len: 4'd3,  wdata: 8'h00, stall_pct: 0,  exp_cs: 4,  exp_done: 12};
    vecs[5] = '{we: 1'b0, addr: 4'd15, len: 4'd0,  wdata: 8'h00, stall_pct: 40, exp_cs: 1,  exp_done: -1};

    repeat (2) @(negedge clk);
    checkOutput("rstReqReady", {31'b0, req_ready}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstMemCs", {31'b0, mem_cs}, 32'd0);
    checkOutput("rstRwBar", {31'b0, mem_rw_bar}, 32'd1);
    checkOutput("rstAbus", mem_abus, 32'd0);
    checkOutput("rstWdata", mem_wdata, 32'd0);
    checkOutput("rstRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rstRspData", rsp_data, 32'd0);
    checkOutput("rstRspAddr", rsp_addr, 32'd0);
    checkOutput("rstWrDone", {31'b0, wr_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterRst", {31'b0, req_ready}, 32'd1);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      runRequest(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].wdata,
                 vecs[i].stall_pct, vecs[i].exp_cs, vecs[i].exp_done);
    end
    checkSram();

    $display("[TB] preload and backpressured burst read");
    for (int k = 0; k < 16; k++) runRequest(1'b1, 4'(k), 4'd0, 8'(k * 17), 0, 1, 2);
    runRequest(1'b0, 4'd0, 4'd15, 8'h00, 50, 16, -1);

    $display("[TB] reset mid-burst");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd15, 8'h00);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midRstMemCs", {31'b0, mem_cs}, 32'd0);
    checkOutput("midRstRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstReady", {31'b0, req_ready}, 32'd1);
    checkOutput("midRstRspValidAfter", {31'b0, rsp_valid}, 32'd0);

    $display("[TB] back-to-back read then write");
    acc0 = accept_count;
    hs0 = hs_count;
    exp_rd = ref_mem[5];
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 4'd5, 4'd0, 8'h00);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_len   = 4'd1;
    req_wdata = 8'h77;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!wr_done && guard < 100);
    rsp_ready = 1'b0;
    checkOutput("b2bWrDone", {31'b0, wr_done}, 32'd1);
    checkOutput("b2bAccepts", accept_count - acc0, 32'd2);
    checkOutput("b2bHandshakes", hs_count - hs0, 32'd1);
    checkOutput("b2bReadData", last_rsp_data, exp_rd);
    ref_mem[5] = 8'h77;
    ref_mem[6] = 8'h77;
    checkSram();

    $display("[TB] random requests");
    for (int i = 0; i < 25; i++) begin
      logic       we;
      logic [3:0] addr;
      logic [3:0] len;
      int         stall;
      we    = 1'($urandom_range(0, 1));
      addr  = 4'($urandom_range(0, 15));
      len   = 4'($urandom_range(0, 15));
      stall = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(10, 60));
      runRequest(we, addr, len, 8'($urandom_range(0, 255)), stall, int'(len) + 1,
                 we ? int'(len) + 2 : (stall == 0 ? 3 * (int'(len) + 1) : -1));
    end
    checkSram();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
